pci_t_stream_wfifo: RTL and testbench

- Target-side application stage directly downstream of the PCI target core.
- Consumes the core's application handshake (t_rd/t_wr/t_we/t_nextd, app_adr/app_adi, t_barhit, t_be_n) and returns t_drdy/t_term/t_abort, app_ado and app_int_n.
- Exposes a 16-byte register window on BAR0: a data port, status, control and interrupt status.
- Words written to the data port are buffered in a FIFO. The FIFO feeds the JPEG decoder input through a first-word-fall-through valid/ready stream.

---
 rtl/pci_t_stream_wfifo.sv | 144 ++++++++++++++
 tb/tb_pci_t_stream_wfifo.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_t_stream_wfifo.sv
// PCI target application stage: BAR0 register window with a write FIFO that
// streams words to the JPEG decoder through a first-word-fall-through port.
module pci_t_stream_wfifo #(
    parameter int DEPTH_LOG2 = 9,
    parameter int LWM        = 64
) (
    input  logic        pci_clk,
    input  logic        pci_rst,
    input  logic [31:0] app_adr,
    input  logic [31:0] app_adi,
    output logic [31:0] app_ado,
    output logic        app_int_n,
    input  logic [5:0]  t_barhit,
    input  logic [3:0]  t_be_n,
    input  logic        t_rd,
    input  logic        t_wr,
    input  logic        t_we,
    input  logic        t_nextd,
    output logic        t_drdy,
    output logic        t_term,
    output logic        t_abort,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_IRQ    = 2'd3;
    localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LWM_LVL  = (DEPTH_LOG2+1)'(LWM);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    // Bit order matches irq_stat so the interrupt mask is a plain AND.
    typedef struct packed {
        logic ien_ovf;
        logic ien_lwm;
    } ctrl_t;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [DEPTH_LOG2:0]   level, level_nxt;
    ctrl_t                 ctrl;
    logic [1:0]            irq_stat, irq_set, irq_clr;
    logic                  rd_valid;

    logic        sel, bad_adr, is_data, full, empty, abort, wr_ok, wr_en;
    logic        ctrl_wr, irq_wr, flush, push, pop;
    logic [1:0]  off;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign unused_ok = ^{t_barhit[5:1], app_adr[31:8], app_adr[1:0], app_adi[31:3]};

    assign sel     = t_barhit[0];
    assign off     = app_adr[3:2];
    assign bad_adr = |app_adr[7:4];
    assign is_data = (off == OFF_DATA);
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);

    assign abort   = (t_rd | t_wr) & sel & (bad_adr | (t_wr & is_data & (t_be_n != 4'b0000)));
    assign wr_ok   = t_wr & sel & ~abort & ~(is_data & full);
    assign t_abort = abort;
    assign t_term  = t_wr & sel & is_data & full & ~abort;
    assign t_drdy  = wr_ok | (t_rd & sel & rd_valid & ~abort);

    // Register bits all live in byte 0, so only t_be_n[0] gates them.
    assign wr_en   = t_we & wr_ok;
    assign ctrl_wr = wr_en & (off == OFF_CTRL) & ~t_be_n[0];
    assign irq_wr  = wr_en & (off == OFF_IRQ) & ~t_be_n[0];
    assign flush   = ctrl_wr & app_adi[0];
    assign push    = wr_en & is_data;
    assign pop     = out_valid & out_ready;

    assign out_valid = ~empty;
    assign out_data  = mem[rptr];

    always_comb begin
        level_nxt = level;
        if (flush)
            level_nxt = '0;
        else if (push & ~pop)
            level_nxt = level + LVL_ONE;
        else if (pop & ~push)
            level_nxt = level - LVL_ONE;
    end

    assign irq_set = {t_term & t_we, (level >= LWM_LVL) & (level_nxt < LWM_LVL)};
    assign irq_clr = irq_wr ? app_adi[1:0] : 2'b00;

    always_comb begin
        rd_mux = '0;
        if (sel & ~bad_adr) begin
            case (off)
                OFF_STATUS: begin
                    rd_mux[DEPTH_LOG2:0] = level;
                    rd_mux[16]           = empty;
                    rd_mux[17]           = full;
                end
                OFF_CTRL: rd_mux[2:1] = ctrl;
                OFF_IRQ:  rd_mux[1:0] = irq_stat;
                default:  rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge pci_clk) begin
        if (push)
            mem[wptr] <= app_adi;
    end

    always_ff @(posedge pci_clk) begin
        if (pci_rst) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            ctrl      <= '0;
            irq_stat  <= '0;
            app_int_n <= 1'b1;
            rd_valid  <= 1'b0;
            app_ado   <= '0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + PTR_ONE;
                if (pop)  rptr <= rptr + PTR_ONE;
            end
            level     <= level_nxt;
            if (ctrl_wr)
                ctrl <= ctrl_t'(app_adi[2:1]);
            irq_stat  <= (irq_stat & ~irq_clr) | irq_set;
            app_int_n <= ~|(irq_stat & ctrl);
            // Read data is captured once per phase; t_nextd forces a re-sample.
            rd_valid  <= t_rd & ~t_nextd;
            if (t_rd & ~rd_valid)
                app_ado <= rd_mux;
        end
    end
endmodule

// File: tb/tb_pci_t_stream_wfifo.sv
// Bench for pci_t_stream_wfifo: vector table, directed corner sequences and
// random traffic, all compared each cycle against a queue-based model.
module tb_pci_t_stream_wfifo;
    localparam int DEPTH = 512;
    localparam int LWM   = 64;

    logic        pci_clk = 1'b0;
    logic        pci_rst = 1'b1;
    logic [31:0] app_adr = '0, app_adi = '0;
    logic [31:0] app_ado, out_data;
    logic        app_int_n, t_drdy, t_term, t_abort, out_valid;
    logic [5:0]  t_barhit = '0;
    logic [3:0]  t_be_n = '0;
    logic        t_rd = 1'b0, t_wr = 1'b0, t_we = 1'b0, t_nextd = 1'b0, out_ready = 1'b0;

    int   checks = 0, failures = 0;
    bit   rand_ready = 1'b0;
    logic [5:0] bar = 6'h01;

    always #5 pci_clk = ~pci_clk;

    pci_t_stream_wfifo #(.DEPTH_LOG2(9), .LWM(LWM)) dut (
        .pci_clk(pci_clk), .pci_rst(pci_rst),
        .app_adr(app_adr), .app_adi(app_adi), .app_ado(app_ado), .app_int_n(app_int_n),
        .t_barhit(t_barhit), .t_be_n(t_be_n), .t_rd(t_rd), .t_wr(t_wr), .t_we(t_we),
        .t_nextd(t_nextd), .t_drdy(t_drdy), .t_term(t_term), .t_abort(t_abort),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    logic        m_live = 1'b0, m_rdv = 1'b0, m_fresh = 1'b0, m_int_n = 1'b1;
    logic        m_len = 1'b0, m_oen = 1'b0;
    logic [1:0]  m_irq = '0;
    logic [31:0] m_sample = '0;

    function automatic logic [31:0] m_reg(input logic [1:0] off);
        case (off)
            2'd1:    return {14'd0, (mq.size() == DEPTH), (mq.size() == 0), 16'(mq.size())};
            2'd2:    return {29'd0, m_oen, m_len, 1'b0};
            2'd3:    return {30'd0, m_irq};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic sel, bad, is_data, full, e_abort, e_term, e_wrdy, e_rrdy, wen, push, pop, flush;
        logic [1:0] off, w1c, irq_s;
        int old_lvl;
        if (pci_rst) begin
            mq.delete();
            m_irq = '0; m_len = 0; m_oen = 0; m_int_n = 1;
            m_rdv = 0; m_fresh = 0; m_live = 1;
            return;
        end
        if (!m_live) return;
        sel     = t_barhit[0];
        off     = app_adr[3:2];
        bad     = (app_adr[7:4] != 4'd0);
        is_data = (off == 2'd0);
        full    = (mq.size() == DEPTH);
        e_abort = (t_rd | t_wr) & sel & (bad | (t_wr & is_data & (t_be_n != 4'd0)));
        e_term  = t_wr & sel & is_data & full & !e_abort;
        e_wrdy  = t_wr & sel & !e_abort & !(is_data & full);
        e_rrdy  = t_rd & sel & m_rdv & !e_abort;
        chk1("t_abort", t_abort, e_abort);
        chk1("t_term", t_term, e_term);
        chk1("t_drdy", t_drdy, e_wrdy | e_rrdy);
        chk1("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) chk("out_data", out_data, mq[0]);
        chk1("app_int_n", app_int_n, m_int_n);
        if (e_rrdy && m_fresh) chk("app_ado", app_ado, m_sample);

        wen   = t_we & e_wrdy;
        push  = wen & is_data;
        pop   = (mq.size() != 0) & out_ready;
        flush = wen & (off == 2'd2) & !t_be_n[0] & app_adi[0];
        w1c   = (wen && off == 2'd3 && !t_be_n[0]) ? app_adi[1:0] : 2'b00;
        if (t_rd && !m_rdv) m_sample = m_reg(off);
        m_fresh = t_rd && !m_rdv && !t_nextd;
        m_rdv   = t_rd && !t_nextd;
        m_int_n = !(|(m_irq & {m_oen, m_len}));
        old_lvl = mq.size();
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(app_adi);
        end
        irq_s = {e_term & t_we, (old_lvl >= LWM) && (mq.size() < LWM)};
        m_irq = (m_irq & ~w1c) | irq_s;
        if (wen && off == 2'd2 && !t_be_n[0]) begin
            m_len = app_adi[1];
            m_oen = app_adi[2];
        end
    endtask

    initial forever begin
        @(negedge pci_clk);
        model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge pci_clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_wr(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] be,
                         output logic ab, output logic dr, output logic tm);
        app_adr = adr; app_adi = data; t_be_n = be; t_barhit = bar; t_wr = 1; t_we = 1;
        @(negedge pci_clk);
        ab = t_abort; dr = t_drdy; tm = t_term;
        cyc();
        t_wr = 0; t_we = 0; t_barhit = '0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] data);
        logic a, d, t;
        do_wr(adr, data, 4'h0, a, d, t);
    endtask

    task automatic do_rd(input logic [31:0] adr, output logic [31:0] d);
        app_adr = adr; t_barhit = 6'h01; t_be_n = '0; t_rd = 1;
        cyc();
        t_nextd = 1;
        @(negedge pci_clk);
        d = app_ado;
        cyc();
        t_rd = 0; t_nextd = 0; t_barhit = '0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 15;

    initial begin
        vec_t        tbl[NV];
        logic        a, d, t;
        logic [31:0] rd, rv;
        int          r;

        // write: exp is t_abort; read: exp is app_ado
        tbl[0]  = '{1'b0, 32'h04, 32'h0,  4'h0, 32'h0001_0000};
        tbl[1]  = '{1'b1, 32'h08, 32'h6,  4'he, 32'h0};
        tbl[2]  = '{1'b0, 32'h08, 32'h0,  4'h0, 32'h6};
        tbl[3]  = '{1'b1, 32'h10, 32'h5,  4'h0, 32'h1};
        tbl[4]  = '{1'b1, 32'h00, 32'h5,  4'hc, 32'h1};
        tbl[5]  = '{1'b0, 32'h04, 32'h0,  4'h0, 32'h0001_0000};
        tbl[6]  = '{1'b1, 32'h00, 32'h11, 4'h0, 32'h0};
        tbl[7]  = '{1'b0, 32'h04, 32'h0,  4'h0, 32'h1};
        tbl[8]  = '{1'b0, 32'h00, 32'h0,  4'h0, 32'h0};
        tbl[9]  = '{1'b1, 32'h08, 32'h1,  4'h0, 32'h0};
        tbl[10] = '{1'b0, 32'h08, 32'h0,  4'h0, 32'h0};
        tbl[11] = '{1'b0, 32'h04, 32'h0,  4'h0, 32'h0001_0000};
        tbl[12] = '{1'b1, 32'h08, 32'h6,  4'h1, 32'h0};
        tbl[13] = '{1'b0, 32'h08, 32'h0,  4'h0, 32'h0};
        tbl[14] = '{1'b0, 32'h0c, 32'h0,  4'h0, 32'h0};

        cyc(); cyc();
        pci_rst = 0;
        @(negedge pci_clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_int_n", app_int_n, 1'b1);
        chk1("rst_drdy", t_drdy, 1'b0);
        chk("rst_ado", app_ado, 32'h0);
        cyc();

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].wr) begin
                do_wr(tbl[i].adr, tbl[i].data, tbl[i].be, a, d, t);
                chk($sformatf("vec%0d_abort", i), {31'd0, a}, tbl[i].exp);
            end else begin
                do_rd(tbl[i].adr, rd);
                chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp);
            end
        end

        // burst of four, then drain in four consecutive cycles
        for (int i = 0; i < 4; i++) wr(32'h0, 32'h11 * (i + 1));
        @(negedge pci_clk);
        chk1("A_valid", out_valid, 1'b1);
        chk("A_head", out_data, 32'h11);
        cyc();
        do_rd(32'h4, rd);
        chk("A_level", rd, 32'd4);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pci_clk);
            chk($sformatf("A_pop%0d", i), out_data, 32'h11 * (i + 1));
            cyc();
        end
        out_ready = 0;
        @(negedge pci_clk);
        chk1("A_empty", out_valid, 1'b0);
        cyc();

        // fill to full, overflow retry and its interrupt
        for (int i = 0; i < DEPTH; i++) wr(32'h0, i);
        do_rd(32'h4, rd);
        chk("B_status_full", rd, 32'h0002_0200);
        do_wr(32'h0, 32'hdead, 4'h0, a, d, t);
        chk1("B_term", t, 1'b1);
        chk1("B_drdy", d, 1'b0);
        do_rd(32'hc, rd);
        chk("B_irq", rd, 32'h2);
        wr(32'h8, 32'h4);
        cyc();
        @(negedge pci_clk);
        chk1("B_int_n", app_int_n, 1'b0);
        cyc();
        wr(32'hc, 32'h2);
        cyc();
        @(negedge pci_clk);
        chk1("B_int_n_clr", app_int_n, 1'b1);
        cyc();
        wr(32'h8, 32'h1);
        wr(32'hc, 32'h3);
        do_rd(32'hc, rd);
        chk("B_irq_clr", rd, 32'h0);

        // low-watermark crossing by one pop
        for (int i = 0; i < LWM; i++) wr(32'h0, 32'h1000 + i);
        wr(32'h8, 32'h2);
        out_ready = 1;
        cyc();
        out_ready = 0;
        do_rd(32'hc, rd);
        chk("C_irq", rd, 32'h1);
        do_rd(32'h4, rd);
        chk("C_level", rd, 32'd63);
        @(negedge pci_clk);
        chk1("C_int_n", app_int_n, 1'b0);
        cyc();
        wr(32'h8, 32'h1);
        wr(32'hc, 32'h1);

        // flush coinciding with a pop
        for (int i = 0; i < 10; i++) wr(32'h0, i);
        out_ready = 1;
        wr(32'h8, 32'h1);
        out_ready = 0;
        @(negedge pci_clk);
        chk1("D_valid", out_valid, 1'b0);
        cyc();
        do_rd(32'h4, rd);
        chk("D_level", rd, 32'h0001_0000);
        do_rd(32'h8, rd);
        chk("D_ctrl", rd, 32'h0);

        // reset in the middle of a write burst
        wr(32'h0, 32'h1);
        wr(32'h0, 32'h2);
        wr(32'h8, 32'h6);
        app_adr = 0; app_adi = 3; t_barhit = 6'h01; t_wr = 1; t_we = 1; pci_rst = 1;
        cyc();
        t_wr = 0; t_we = 0; t_barhit = '0; pci_rst = 0;
        @(negedge pci_clk);
        chk1("R_valid", out_valid, 1'b0);
        chk1("R_int_n", app_int_n, 1'b1);
        cyc();
        do_rd(32'h8, rd);
        chk("R_ctrl", rd, 32'h0);
        do_rd(32'h4, rd);
        chk("R_status", rd, 32'h0001_0000);

        // random traffic, checked by the model every cycle
        rand_ready = 1;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                do_wr(32'h0, $urandom,
                      ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, a, d, t);
            end else if (r < 60) begin
                rv = '0;
                rv[3:2] = 2'($urandom_range(0, 3));
                do_rd(rv, rd);
            end else if (r < 66) begin
                rv = $urandom & 32'hFFFF_FFFE;
                if ($urandom_range(0, 7) == 0) rv[0] = 1'b1;
                do_wr(32'h8, rv, 4'($urandom_range(0, 15)), a, d, t);
            end else if (r < 72) begin
                do_wr(32'hc, $urandom, 4'($urandom_range(0, 15)), a, d, t);
            end else if (r < 76) begin
                rv = $urandom;
                rv[7:4] = 4'($urandom_range(1, 15));
                do_wr(rv, $urandom, 4'h0, a, d, t);
            end else if (r < 80) begin
                bar = 6'h02;
                do_wr(32'h0, $urandom, 4'h0, a, d, t);
                bar = 6'h01;
            end else begin
                cyc();
            end
        end
        rand_ready = 0;
        out_ready = 0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
